toast_divider: RTL
==================

# toast_divider

Multi-cycle RV32M division unit in the EX stage, next to the single-cycle ALU. It executes DIV, DIVU, REM and REMU using radix-2 restoring division, one quotient bit per clock. It signals completion with a one-cycle done pulse. The pipeline stalls on `div_busy_o` while the operation is in flight.

## Interface
Parameters:
- none; the datapath is fixed at 32 bits.

Ports:
- `clk_i` input 1: clock. Single clock domain; all state updates on the rising edge.
- `reset_i` input 1: reset, asynchronous, active-high.
- `div_start_i` input 1: request. Sampled only in IDLE or DONE.
- `div_op_i` input 2: operation select. 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU.
- `div_op1_i` input 32: dividend. Captured on accepted start.
- `div_op2_i` input 32: divisor. Captured on accepted start.
- `div_flush_i` input 1: abort the in-flight operation (pipeline flush).
- `div_result_o` output 32: registered result. Holds its value until the next completion.
- `div_busy_o` output 1: high while in CALC.
- `div_done_o` output 1: high for exactly one cycle when `div_result_o` is newly valid.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations in progress.
  - DONE: one cycle, presenting the done pulse.
- Transitions:
  - IDLE or DONE, start=1, flush=0, normal operands: go to CALC.
  - IDLE or DONE, start=1, flush=0, special case: go directly to DONE.
  - IDLE or DONE, start=0: go to IDLE.
  - CALC, iteration counter=31: go to DONE.
  - Any state, `div_flush_i`=1: go to IDLE. Flush has priority over start and completion.
- Accepted start latches:
  - op;
  - sign flags: quotient sign = op1[31]^op2[31] and remainder sign = op1[31], both for signed ops only;
  - magnitude operands: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - It also clears the 64-bit {remainder, quotient} register and the 5-bit counter.
- Each CALC cycle:
  - shift {rem, quo} left by 1;
  - trial subtract the divisor magnitude from the upper 33 bits;
  - if the result is non-negative, keep the difference and set quo[0]=1; otherwise restore.
  - The counter increments; 31 is the final iteration.
- On the final iteration, sign correction is applied combinationally and the result is written to `div_result_o`:
  - quotient is negated if the quotient sign flag is set;
  - remainder is negated if the remainder sign flag is set;
  - DIV/DIVU return the quotient, REM/REMU return the remainder.
- Special cases skip CALC and write `div_result_o` on the start edge:
  - Divisor = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF (signed overflow): DIV gives 0x80000000; REM gives 0.
- Start while in CALC is ignored. The upstream stage holds its request until it sees done.
- Start in the DONE cycle is accepted, giving back-to-back operation with no IDLE bubble.
- Flush:
  - no done pulse is produced;
  - `div_result_o` keeps its previous value;
  - the partial result is discarded.
- Reset, including mid-operation: state=IDLE, `div_result_o`=0, `div_busy_o`=0, `div_done_o`=0, counter and working registers cleared.

## Timing
- Start is sampled at edge N.
- Normal path:
  - `div_busy_o`=1 in the 32 cycles following edges N..N+31;
  - the final iteration runs at edge N+32;
  - `div_result_o` is valid and `div_done_o`=1 in the cycle after edge N+32;
  - latency is 33 cycles from the start cycle to the done cycle.
- Special path:
  - `div_busy_o` stays 0;
  - `div_done_o`=1 and the result is valid in the cycle after edge N (latency 1).
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Asynchronous reset takes effect immediately without a clock. Deassertion is synchronous to `clk_i`, handled externally.

## Test plan
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> done at cycle 33, result 0xFFFFFFFD (-3). Repeat with REM -> 0xFFFFFFFF (-1). REMU 7/0xFFFFFFFE -> 7.
- DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. `div_busy_o` high for exactly 32 cycles in each case.
- Divide by zero, DIV 1234/0 -> 0xFFFFFFFF, and REM 1234/0 -> 1234, each with done one cycle after start. Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Flush asserted at CALC cycle 10 -> IDLE next cycle, no done pulse, `div_result_o` unchanged. Start and flush together in IDLE -> request not accepted.
- Reset asserted asynchronously mid-CALC -> all outputs 0 immediately. After release, a new DIVU 9/3 -> 3.
- Back-to-back: second start asserted during the DONE cycle -> second done exactly 33 cycles later. Start pulses during CALC are ignored, and the first result is unaffected.

Source files
------------

// File: rtl/toast_divider_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
interface toast_divider_if;
  logic        div_start_i;
  logic [1:0]  div_op_i;
  logic [31:0] div_op1_i;
  logic [31:0] div_op2_i;
  logic        div_flush_i;
  logic [31:0] div_result_o;
  logic        div_busy_o;
  logic        div_done_o;

  // Pipeline side: issues requests and consumes the result.
  modport master (
    output div_start_i, div_op_i, div_op1_i, div_op2_i, div_flush_i,
    input  div_result_o, div_busy_o, div_done_o
  );

  // Divider side.
  modport slave (
    input  div_start_i, div_op_i, div_op1_i, div_op2_i, div_flush_i,
    output div_result_o, div_busy_o, div_done_o
  );
endinterface

// File: rtl/toast_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit
// per clock, with divide-by-zero and signed-overflow results returned in one cycle.
module toast_divider (
  input  logic                  clk_i,
  input  logic                  reset_i,
  toast_divider_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // op encoding: bit 1 selects remainder, bit 0 selects unsigned
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_REM = 2'b10;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] dsr_q, dsr_d;       // divisor magnitude
  logic [63:0] acc_q, acc_d;       // {remainder, quotient}
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Decode of the incoming request
  logic        req_signed;
  logic [31:0] op1_mag, op2_mag;
  logic        div_by_zero, sgn_overflow, special;
  logic [31:0] special_res;

  // One iteration of restoring division on the current working register
  logic [32:0] trial;
  logic [63:0] acc_iter;
  logic [31:0] quo_fin, rem_fin, calc_res;

  // Operand decode: magnitudes, sign flags and the single-cycle special results.
  always_comb begin
    req_signed   = ~bus.div_op_i[0];
    op1_mag      = (req_signed && bus.div_op1_i[31]) ? -bus.div_op1_i : bus.div_op1_i;
    op2_mag      = (req_signed && bus.div_op2_i[31]) ? -bus.div_op2_i : bus.div_op2_i;
    div_by_zero  = (bus.div_op2_i == 32'd0);
    sgn_overflow = req_signed && (bus.div_op1_i == 32'h8000_0000) &&
                   (bus.div_op2_i == 32'hFFFF_FFFF);
    special      = div_by_zero || sgn_overflow;
    if (div_by_zero) begin
      special_res = bus.div_op_i[1] ? bus.div_op1_i : 32'hFFFF_FFFF;
    end else begin
      special_res = bus.div_op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Datapath step: shift, trial subtract, keep or restore; plus sign correction.
  always_comb begin
    // Shifted remainder needs 33 bits; bit 32 of the difference is the borrow.
    trial = acc_q[63:31] - {1'b0, dsr_q};
    if (!trial[32]) begin
      acc_iter = {trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_iter = {acc_q[62:0], 1'b0};
    end
    quo_fin  = quo_neg_q ? -acc_iter[31:0]  : acc_iter[31:0];
    rem_fin  = rem_neg_q ? -acc_iter[63:32] : acc_iter[63:32];
    calc_res = op_q[1] ? rem_fin : quo_fin;
  end

  // Next-state and register-update logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    dsr_d     = dsr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (bus.div_flush_i) begin
      // Flush wins over start and completion; the result register is untouched.
      state_d = ST_IDLE;
      acc_d   = 64'd0;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.div_start_i) begin
            op_d      = bus.div_op_i;
            quo_neg_d = req_signed && (bus.div_op1_i[31] ^ bus.div_op2_i[31]);
            rem_neg_d = req_signed && bus.div_op1_i[31];
            dsr_d     = op2_mag;
            acc_d     = {32'd0, op1_mag};
            cnt_d     = 5'd0;
            if (special) begin
              result_d = special_res;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          acc_d = acc_iter;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = calc_res;
            state_d  = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DIV;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dsr_q     <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      result_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      dsr_q     <= dsr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // Outputs come straight from registers or a state decode.
  assign bus.div_result_o = result_q;
  assign bus.div_busy_o   = (state_q == ST_CALC);
  assign bus.div_done_o   = (state_q == ST_DONE);

  // REM encoding kept visible for readers mapping funct3 to op.
  logic unused_op_rem;
  assign unused_op_rem = (op_q == OP_REM);

endmodule
